// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline controller: sequencer states and register-select width.
package cpu_types_pkg;

    localparam int REG_BITS = 5;

    typedef logic [REG_BITS-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DHELD  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

    // A destination of r0 never creates a dependency because r0 is hard-wired to zero.
    function automatic logic reg_matches(input regbits_t dst, input regbits_t src);
        return (dst != {REG_BITS{1'b0}}) && (dst == src);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: a load in ID_EX whose destination feeds the
// instruction currently in IF_ID.
module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic     memRead_ex,
    input  regbits_t wsel_ex,
    input  regbits_t rs_id,
    input  regbits_t rt_id,
    output logic     luse
);

    // Hazard when the load target matches either source operand (never r0).
    always_comb begin
        luse = 1'b0;
        if (memRead_ex) begin
            luse = reg_matches(wsel_ex, rs_id) | reg_matches(wsel_ex, rt_id);
        end else begin
            luse = 1'b0;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage pipeline: pipe enables/flushes, PC enable,
// shared memory port arbitration, load-use stall, MEM redirect and halt.
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dREN_mem,
    input  logic             dWEN_mem,
    input  logic [31:0]      dmemload_i,
    input  logic             memRead_ex,
    input  logic [REG_W-1:0] wsel_ex,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             redirect_mem,
    input  logic             halt_wb,
    output logic             pc_EN,
    output logic             if_id_EN,
    output logic             if_id_flush,
    output logic             id_ex_EN,
    output logic             id_ex_flush,
    output logic             ex_mem_EN,
    output logic             ex_mem_flush,
    output logic             mem_wb_EN,
    output logic             mem_wb_flush,
    output logic             dmem_mask,
    output logic [31:0]      dmemload_o,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    ctrl_state_t      state_q, state_d;
    logic [31:0]      hold_q, hold_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             memreq;
    logic             advance;
    logic             luse;

    load_use_detect u_luse (
        .memRead_ex (memRead_ex),
        .wsel_ex    (regbits_t'(wsel_ex)),
        .rs_id      (regbits_t'(rs_id)),
        .rt_id      (regbits_t'(rt_id)),
        .luse       (luse)
    );

    // Memory arbitration: once data is held, the data side no longer blocks fetch.
    always_comb begin
        memreq  = (dREN_mem | dWEN_mem) & (state_q != DHELD);
        advance = ihit & (~memreq | dhit | (state_q == DHELD));
    end

    // Next state, hold capture and saturating stall count.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        stall_d = stall_q;
        case (state_q)
            RUN: begin
                if (halt_wb) begin
                    state_d = HALTED;
                end else if (memreq && dhit && !ihit) begin
                    state_d = DHELD;
                    hold_d  = dmemload_i;
                end else begin
                    state_d = RUN;
                end
            end
            DHELD: begin
                if (halt_wb) begin
                    state_d = HALTED;
                end else if (ihit) begin
                    state_d = RUN;
                end else begin
                    state_d = DHELD;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if ((state_q != HALTED) && !advance && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_d = stall_q;
        end
    end

    // Sequencer register with hold data and stall counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            hold_q  <= 32'h0000_0000;
            stall_q <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            stall_q <= stall_d;
        end
    end

    // Output decode: redirect outranks load-use; nothing moves without advance.
    always_comb begin
        pc_EN        = 1'b0;
        if_id_EN     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_EN     = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_EN    = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_EN    = 1'b0;
        mem_wb_flush = 1'b0;
        if ((state_q != HALTED) && advance) begin
            id_ex_EN  = 1'b1;
            ex_mem_EN = 1'b1;
            mem_wb_EN = 1'b1;
            if (redirect_mem) begin
                pc_EN        = 1'b1;
                if_id_EN     = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (luse) begin
                pc_EN       = 1'b0;
                if_id_EN    = 1'b0;
                id_ex_flush = 1'b1;
            end else begin
                pc_EN    = 1'b1;
                if_id_EN = 1'b1;
            end
        end else begin
            pc_EN = 1'b0;
        end
        dmem_mask    = (state_q != RUN);
        dmemload_o   = (state_q == RUN) ? dmemload_i : hold_q;
        halted       = (state_q == HALTED);
        stall_cycles = stall_q;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed, table-driven bench for pipeline_ctrl.
module tb_pipeline_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, dREN_mem, dWEN_mem, memRead_ex, redirect_mem, halt_wb;
    logic [31:0] dmemload_i;
    logic [4:0]  wsel_ex, rs_id, rt_id;
    logic        pc_EN, if_id_EN, if_id_flush, id_ex_EN, id_ex_flush;
    logic        ex_mem_EN, ex_mem_flush, mem_wb_EN, mem_wb_flush;
    logic        dmem_mask, halted;
    logic [31:0] dmemload_o, stall_cycles;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 CLK = ~CLK;

    pipeline_ctrl #(.CNT_W(32), .REG_W(5)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .dmemload_i(dmemload_i),
        .memRead_ex(memRead_ex), .wsel_ex(wsel_ex), .rs_id(rs_id), .rt_id(rt_id),
        .redirect_mem(redirect_mem), .halt_wb(halt_wb),
        .pc_EN(pc_EN), .if_id_EN(if_id_EN), .if_id_flush(if_id_flush),
        .id_ex_EN(id_ex_EN), .id_ex_flush(id_ex_flush),
        .ex_mem_EN(ex_mem_EN), .ex_mem_flush(ex_mem_flush),
        .mem_wb_EN(mem_wb_EN), .mem_wb_flush(mem_wb_flush),
        .dmem_mask(dmem_mask), .dmemload_o(dmemload_o),
        .halted(halted), .stall_cycles(stall_cycles)
    );

    // c = {ihit, dhit, dREN, dWEN, memRead_ex, redirect, halt}
    // ectl = {pc, if_id_EN, if_id_fl, id_ex_EN, id_ex_fl, ex_mem_EN, ex_mem_fl, mem_wb_EN, mem_wb_fl}
    typedef struct {
        logic [6:0]  c;
        logic [4:0]  wsel;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] din;
        logic [8:0]  ectl;
        logic        emask;
        logic [31:0] edout;
        logic        ehalt;
        logic [31:0] estall;
    } vec_t;

    localparam logic [8:0] NORM  = 9'b1_1_0_1_0_1_0_1_0;
    localparam logic [8:0] FRZ   = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] LUSE  = 9'b0_0_0_1_1_1_0_1_0;
    localparam logic [8:0] REDIR = 9'b1_1_1_1_1_1_1_1_0;
    localparam int NV = 22;

    vec_t vecs [NV];

    function automatic logic [8:0] ctl_now();
        return {pc_EN, if_id_EN, if_id_flush, id_ex_EN, id_ex_flush,
                ex_mem_EN, ex_mem_flush, mem_wb_EN, mem_wb_flush};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        ihit = 1'b0; dhit = 1'b0; dREN_mem = 1'b0; dWEN_mem = 1'b0;
        memRead_ex = 1'b0; redirect_mem = 1'b0; halt_wb = 1'b0;
        wsel_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0; dmemload_i = 32'h0;
    endtask

    task automatic drive_vec(input vec_t v);
        {ihit, dhit, dREN_mem, dWEN_mem, memRead_ex, redirect_mem, halt_wb} = v.c;
        wsel_ex = v.wsel; rs_id = v.rs; rt_id = v.rt; dmemload_i = v.din;
    endtask

    initial begin
        // Test 1: normal advance
        vecs[0]  = '{7'b1000000, 5'd0, 5'd0, 5'd0, 32'h1111_1111, NORM, 1'b0, 32'h1111_1111, 1'b0, 32'd0};
        vecs[1]  = '{7'b1000000, 5'd0, 5'd0, 5'd0, 32'h2222_2222, NORM, 1'b0, 32'h2222_2222, 1'b0, 32'd0};
        // Test 2: data miss freezes for three cycles
        vecs[2]  = '{7'b1010000, 5'd0, 5'd0, 5'd0, 32'h0, FRZ, 1'b0, 32'h0, 1'b0, 32'd0};
        vecs[3]  = '{7'b1010000, 5'd0, 5'd0, 5'd0, 32'h0, FRZ, 1'b0, 32'h0, 1'b0, 32'd1};
        vecs[4]  = '{7'b1010000, 5'd0, 5'd0, 5'd0, 32'h0, FRZ, 1'b0, 32'h0, 1'b0, 32'd2};
        vecs[5]  = '{7'b1110000, 5'd0, 5'd0, 5'd0, 32'h0000_A5A5, NORM, 1'b0, 32'h0000_A5A5, 1'b0, 32'd3};
        vecs[6]  = '{7'b0001000, 5'd0, 5'd0, 5'd0, 32'h0, FRZ, 1'b0, 32'h0, 1'b0, 32'd3};
        // Test 3: data returns before fetch, held in DHELD
        vecs[7]  = '{7'b0110000, 5'd0, 5'd0, 5'd0, 32'hDEAD_BEEF, FRZ, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'd4};
        vecs[8]  = '{7'b0010000, 5'd0, 5'd0, 5'd0, 32'h0, FRZ, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'd5};
        vecs[9]  = '{7'b1010000, 5'd0, 5'd0, 5'd0, 32'h0, NORM, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'd6};
        vecs[10] = '{7'b1000000, 5'd0, 5'd0, 5'd0, 32'h0000_0033, NORM, 1'b0, 32'h0000_0033, 1'b0, 32'd6};
        // Test 4: load-use
        vecs[11] = '{7'b1000100, 5'd5, 5'd5, 5'd0, 32'h0, LUSE, 1'b0, 32'h0, 1'b0, 32'd6};
        vecs[12] = '{7'b1000100, 5'd5, 5'd0, 5'd5, 32'h0, LUSE, 1'b0, 32'h0, 1'b0, 32'd6};
        vecs[13] = '{7'b1000100, 5'd0, 5'd0, 5'd0, 32'h0, NORM, 1'b0, 32'h0, 1'b0, 32'd6};
        vecs[14] = '{7'b1000000, 5'd5, 5'd5, 5'd0, 32'h0, NORM, 1'b0, 32'h0, 1'b0, 32'd6};
        vecs[15] = '{7'b0000100, 5'd5, 5'd5, 5'd0, 32'h0, FRZ, 1'b0, 32'h0, 1'b0, 32'd6};
        // Test 5: redirect over load-use, and ignored without advance
        vecs[16] = '{7'b1000110, 5'd5, 5'd5, 5'd0, 32'h0, REDIR, 1'b0, 32'h0, 1'b0, 32'd7};
        vecs[17] = '{7'b0000110, 5'd5, 5'd5, 5'd0, 32'h0, FRZ, 1'b0, 32'h0, 1'b0, 32'd7};
        // Test 6: halt from DHELD, sticky
        vecs[18] = '{7'b0110000, 5'd0, 5'd0, 5'd0, 32'hCAFE_F00D, FRZ, 1'b0, 32'hCAFE_F00D, 1'b0, 32'd8};
        vecs[19] = '{7'b0000001, 5'd0, 5'd0, 5'd0, 32'h0, FRZ, 1'b1, 32'hCAFE_F00D, 1'b0, 32'd9};
        vecs[20] = '{7'b1110000, 5'd0, 5'd0, 5'd0, 32'h1, FRZ, 1'b1, 32'hCAFE_F00D, 1'b1, 32'd10};
        vecs[21] = '{7'b1000010, 5'd0, 5'd0, 5'd0, 32'h2, FRZ, 1'b1, 32'hCAFE_F00D, 1'b1, 32'd10};

        drive_idle();
        nRST = 1'b0;
        #2;
        check("reset_ctl", {23'd0, ctl_now()}, {23'd0, FRZ});
        check("reset_mask", {31'd0, dmem_mask}, 32'd0);
        check("reset_halted", {31'd0, halted}, 32'd0);
        check("reset_stall", stall_cycles, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive_vec(vecs[i]);
            #1;
            check($sformatf("v%0d_ctl", i), {23'd0, ctl_now()}, {23'd0, vecs[i].ectl});
            check($sformatf("v%0d_mask", i), {31'd0, dmem_mask}, {31'd0, vecs[i].emask});
            check($sformatf("v%0d_dout", i), dmemload_o, vecs[i].edout);
            check($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].ehalt});
            check($sformatf("v%0d_stall", i), stall_cycles, vecs[i].estall);
            @(negedge CLK);
        end

        // Reset asserted while halted: immediate return to RUN, counter cleared.
        drive_idle();
        dmemload_i = 32'h0000_0077;
        nRST = 1'b0;
        #1;
        check("rst_halted_halted", {31'd0, halted}, 32'd0);
        check("rst_halted_mask", {31'd0, dmem_mask}, 32'd0);
        check("rst_halted_stall", stall_cycles, 32'd0);
        check("rst_halted_dout", dmemload_o, 32'h0000_0077);
        @(negedge CLK);
        nRST = 1'b1;

        // Enter DHELD, then reset mid-hold: mask drops and live data passes.
        dREN_mem = 1'b1; dhit = 1'b1; dmemload_i = 32'h1234_5678;
        @(negedge CLK);
        dhit = 1'b0; dmemload_i = 32'h0;
        #1;
        check("dheld_mask", {31'd0, dmem_mask}, 32'd1);
        check("dheld_dout", dmemload_o, 32'h1234_5678);
        nRST = 1'b0;
        #1;
        check("rst_dheld_mask", {31'd0, dmem_mask}, 32'd0);
        check("rst_dheld_dout", dmemload_o, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        drive_idle();
        ihit = 1'b1;
        #1;
        check("post_rst_ctl", {23'd0, ctl_now()}, {23'd0, NORM});
        @(negedge CLK);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
